// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game: colour codes, player-input FSM states
// and the colour-to-LED mapping also used by sequence playback.
package genius_pkg;

    localparam logic [1:0] BLUE   = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;
    localparam logic [1:0] RED    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_KEY,
        ST_CHECK,
        ST_ECHO,
        ST_FINISH
    } state_e;

    function automatic logic [3:0] color_onehot(input logic [1:0] color);
        logic [3:0] led;
        case (color)
            BLUE:    led = 4'b0001;
            YELLOW:  led = 4'b0010;
            GREEN:   led = 4'b0100;
            default: led = 4'b1000;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/genius_cycle_timer.sv
// Terminal-count cycle timer: held at zero by clr_i, counts while en_i, and
// flags the last of CYCLES enabled cycles. Saturates so it can never wrap.
module genius_cycle_timer #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);
    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/genius_player_input.sv
// Player key-entry checker: compares IR key presses against the stored sequence,
// echoes each correct colour on the LEDs, and reports match/timeout/abort.
//   state       | meaning
//   ST_IDLE     | waiting for start from the game FSM
//   ST_WAIT_KEY | waiting for a key press, timeout running
//   ST_CHECK    | compare captured key with sequence memory data
//   ST_ECHO     | correct key lit on LEDs for the echo time
//   ST_FINISH   | one-cycle done pulse, result flags valid
module genius_player_input
    import genius_pkg::*;
#(
    parameter int unsigned LEN_W          = 5,
    parameter int unsigned TIMEOUT_CYCLES = 250000000,
    parameter int unsigned ECHO_CYCLES    = 25000000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] seq_len_i,
    input  logic             ir_rdy_i,
    input  logic [1:0]       ir_color_i,
    input  logic             ir_power_i,
    output logic [LEN_W-1:0] seq_addr_o,
    input  logic [1:0]       seq_color_i,
    output logic             busy_o,
    output logic [3:0]       led_o,
    output logic             done_o,
    output logic             match_o,
    output logic             timeout_o,
    output logic             abort_o
);
    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] addr_q, addr_d;
    logic [1:0]       key_q, key_d;
    logic [3:0]       led_q, led_d;
    logic             match_q, match_d;
    logic             timeout_q, timeout_d;
    logic             abort_q, abort_d;
    logic             to_done, echo_done, last_entry;

    genius_cycle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (state_q != ST_WAIT_KEY),
        .en_i  (state_q == ST_WAIT_KEY),
        .done_o(to_done)
    );

    genius_cycle_timer #(.CYCLES(ECHO_CYCLES)) u_echo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (state_q != ST_ECHO),
        .en_i  (state_q == ST_ECHO),
        .done_o(echo_done)
    );

    assign last_entry = (addr_q == (len_q - LEN_W'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            key_q     <= '0;
            led_q     <= '0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            key_q     <= key_d;
            led_q     <= led_d;
            match_q   <= match_d;
            timeout_q <= timeout_d;
            abort_q   <= abort_d;
        end
    end

    // A key arriving on the timeout terminal cycle wins: ir_rdy is tested first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (seq_len_i == '0) ? ST_FINISH : ST_WAIT_KEY;
                end
            end
            ST_WAIT_KEY: begin
                if (ir_rdy_i) begin
                    state_d = ir_power_i ? ST_FINISH : ST_CHECK;
                end else if (to_done) begin
                    state_d = ST_FINISH;
                end
            end
            ST_CHECK: state_d = (key_q == seq_color_i) ? ST_ECHO : ST_FINISH;
            ST_ECHO: begin
                if (echo_done) begin
                    state_d = last_entry ? ST_FINISH : ST_WAIT_KEY;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        len_d     = len_q;
        addr_d    = addr_q;
        key_d     = key_q;
        led_d     = led_q;
        match_d   = match_q;
        timeout_d = timeout_q;
        abort_d   = abort_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d     = seq_len_i;
                    addr_d    = '0;
                    match_d   = (seq_len_i == '0);
                    timeout_d = 1'b0;
                    abort_d   = 1'b0;
                end
            end
            ST_WAIT_KEY: begin
                if (ir_rdy_i) begin
                    if (ir_power_i) begin
                        abort_d = 1'b1;
                    end else begin
                        key_d = ir_color_i;
                    end
                end else if (to_done) begin
                    timeout_d = 1'b1;
                end
            end
            ST_CHECK: begin
                if (key_q == seq_color_i) begin
                    led_d = color_onehot(key_q);
                end
            end
            ST_ECHO: begin
                if (echo_done) begin
                    led_d = '0;
                    if (last_entry) begin
                        match_d = 1'b1;
                    end else begin
                        addr_d = addr_q + LEN_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_FINISH);
    assign seq_addr_o = addr_q;
    assign led_o      = led_q;
    assign match_o    = match_q;
    assign timeout_o  = timeout_q;
    assign abort_o    = abort_q;

endmodule

// File: tb/tb_genius_player_input.sv
// Bench for genius_player_input with short timer parameters and a
// synchronous-read sequence memory model.
module tb_genius_player_input;
    localparam int LEN_W = 5;
    localparam int TO    = 20;
    localparam int EC    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] seq_len = '0;
    logic             ir_rdy = 1'b0;
    logic [1:0]       ir_color = 2'd0;
    logic             ir_power = 1'b0;
    logic [LEN_W-1:0] seq_addr;
    logic [1:0]       seq_color;
    logic             busy, done, match, timeout, abort;
    logic [3:0]       led;

    logic [1:0] mem [32];
    logic [3:0] led_of [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    int n_tests = 0;
    int n_fail  = 0;

    genius_player_input #(
        .LEN_W(LEN_W), .TIMEOUT_CYCLES(TO), .ECHO_CYCLES(EC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .seq_len_i(seq_len),
        .ir_rdy_i(ir_rdy), .ir_color_i(ir_color), .ir_power_i(ir_power),
        .seq_addr_o(seq_addr), .seq_color_i(seq_color), .busy_o(busy),
        .led_o(led), .done_o(done), .match_o(match), .timeout_o(timeout),
        .abort_o(abort)
    );

    always #5 clk = ~clk;
    always @(posedge clk) seq_color <= mem[seq_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input int len);
        seq_len = LEN_W'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press(input int color, input bit power);
        ir_color = 2'(color);
        ir_power = power;
        ir_rdy = 1'b1;
        tick();
        ir_rdy = 1'b0;
        ir_power = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_tests++; if (led !== 4'b0) begin n_fail++; $display("FAIL reset_led got=%b exp=0000", led); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_tests++; if (seq_addr !== '0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", seq_addr); end
        mem[0] = 2'd2; mem[1] = 2'd3;
        start_round(3);
        press(2, 0); tick();
        repeat (EC) tick();
        press(3, 0); tick();
        n_tests++; if (led !== 4'b1000) begin n_fail++; $display("FAIL pre_reset_led got=%b exp=1000", led); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (led !== 4'b0) begin n_fail++; $display("FAIL async_reset_led got=%b exp=0000", led); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
        n_tests++; if (seq_addr !== '0) begin n_fail++; $display("FAIL async_reset_addr got=%0d exp=0", seq_addr); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done got=%b exp=0", done); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sequence();
        int keys [3] = '{2, 3, 0};
        mem[0] = 2'd2; mem[1] = 2'd3; mem[2] = 2'd0;
        start_round(3);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL seq_busy got=%b exp=1", busy); end
        for (int i = 0; i < 3; i++) begin
            press(keys[i], 0);
            tick();
            n_tests++; if (led !== led_of[keys[i]]) begin n_fail++; $display("FAIL seq_led%0d got=%b exp=%b", i, led, led_of[keys[i]]); end
            n_tests++; if (seq_addr !== LEN_W'(i)) begin n_fail++; $display("FAIL seq_addr%0d got=%0d exp=%0d", i, seq_addr, i); end
            repeat (EC) tick();
            if (i < 2) begin
                n_tests++; if (seq_addr !== LEN_W'(i + 1)) begin n_fail++; $display("FAIL seq_step%0d got=%0d exp=%0d", i, seq_addr, i + 1); end
                n_tests++; if (led !== 4'b0 || done !== 1'b0) begin n_fail++; $display("FAIL seq_gap%0d led=%b done=%b exp led=0000 done=0", i, led, done); end
            end
        end
        n_tests++; if ({done, match, timeout, abort} !== 4'b1100) begin n_fail++; $display("FAIL seq_done got=%b exp=1100", {done, match, timeout, abort}); end
        tick();
        n_tests++; if ({busy, done, match} !== 3'b001) begin n_fail++; $display("FAIL seq_after got=%b exp=001", {busy, done, match}); end
    endtask

    task automatic test_mismatch();
        mem[0] = 2'd2; mem[1] = 2'd3; mem[2] = 2'd0;
        start_round(3);
        press(2, 0); tick();
        repeat (EC) tick();
        press(1, 0); tick();
        n_tests++; if ({done, match} !== 2'b10) begin n_fail++; $display("FAIL mis_done got=%b exp=10", {done, match}); end
        n_tests++; if (led !== 4'b0) begin n_fail++; $display("FAIL mis_led got=%b exp=0000", led); end
        n_tests++; if (seq_addr !== LEN_W'(1)) begin n_fail++; $display("FAIL mis_addr got=%0d exp=1", seq_addr); end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mis_busy got=%b exp=0", busy); end
    endtask

    task automatic test_timeout();
        int n = 0;
        start_round(2);
        while (!done && n < 100) begin
            tick();
            n++;
        end
        n_tests++; if (n !== TO) begin n_fail++; $display("FAIL to_cycles got=%0d exp=%0d", n, TO); end
        n_tests++; if ({match, timeout, abort} !== 3'b010) begin n_fail++; $display("FAIL to_flags got=%b exp=010", {match, timeout, abort}); end
        tick();
    endtask

    task automatic test_abort_and_drop();
        start_round(2);
        press(1, 1);
        n_tests++; if ({done, match, timeout, abort} !== 4'b1001) begin n_fail++; $display("FAIL abort got=%b exp=1001", {done, match, timeout, abort}); end
        tick();
        mem[0] = 2'd1; mem[1] = 2'd2;
        start_round(2);
        press(1, 0); tick();
        n_tests++; if (led !== 4'b0010) begin n_fail++; $display("FAIL drop_led0 got=%b exp=0010", led); end
        press(2, 0);
        repeat (EC - 1) tick();
        n_tests++; if (seq_addr !== LEN_W'(1) || led !== 4'b0) begin n_fail++; $display("FAIL drop_addr addr=%0d led=%b exp addr=1 led=0000", seq_addr, led); end
        repeat (3) tick();
        n_tests++; if (led !== 4'b0 || done !== 1'b0) begin n_fail++; $display("FAIL drop_queued led=%b done=%b exp led=0000 done=0", led, done); end
        press(2, 0); tick();
        n_tests++; if (led !== 4'b0100) begin n_fail++; $display("FAIL drop_led1 got=%b exp=0100", led); end
        repeat (EC) tick();
        n_tests++; if ({done, match} !== 2'b11) begin n_fail++; $display("FAIL drop_done got=%b exp=11", {done, match}); end
        tick();
    endtask

    task automatic test_zero_len_and_busy();
        start_round(0);
        n_tests++; if ({busy, done, match} !== 3'b111) begin n_fail++; $display("FAIL zero_done got=%b exp=111", {busy, done, match}); end
        tick();
        n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL zero_idle got=%b exp=00", {busy, done}); end
        mem[0] = 2'd3; mem[1] = 2'd0;
        start_round(2);
        press(3, 0); tick();
        seq_len = LEN_W'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (EC - 1) tick();
        n_tests++; if ({busy, done, match} !== 3'b100 || seq_addr !== LEN_W'(1)) begin n_fail++; $display("FAIL busy_start bdm=%b addr=%0d exp bdm=100 addr=1", {busy, done, match}, seq_addr); end
        press(0, 0); tick();
        n_tests++; if (led !== 4'b0001) begin n_fail++; $display("FAIL busy_led got=%b exp=0001", led); end
        repeat (EC) tick();
        n_tests++; if ({done, match} !== 2'b11) begin n_fail++; $display("FAIL busy_done got=%b exp=11", {done, match}); end
        tick();
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            int len, kind, end_idx, roll;
            int keys [8];
            bit pw [8];
            logic [2:0] exp_flags;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                mem[i] = 2'($urandom_range(0, 3));
                roll = $urandom_range(0, 15);
                pw[i] = (roll == 0);
                keys[i] = (roll == 1 || roll == 2) ? (int'(mem[i]) + $urandom_range(1, 3)) % 4 : int'(mem[i]);
            end
            kind = 0;
            end_idx = len - 1;
            for (int i = 0; i < len; i++) begin
                if (pw[i]) begin kind = 2; end_idx = i; break; end
                if (keys[i] != int'(mem[i])) begin kind = 1; end_idx = i; break; end
            end
            exp_flags = (kind == 0) ? 3'b100 : (kind == 2) ? 3'b001 : 3'b000;
            start_round(len);
            for (int i = 0; i <= end_idx; i++) begin
                repeat ($urandom_range(0, 5)) tick();
                press(keys[i], pw[i]);
                if (kind == 2 && i == end_idx) break;
                tick();
                if (kind == 1 && i == end_idx) break;
                n_tests++; if (led !== led_of[keys[i]]) begin n_fail++; $display("FAIL rnd%0d_led%0d got=%b exp=%b", r, i, led, led_of[keys[i]]); end
                repeat (EC) tick();
            end
            n_tests++; if ({done, match, timeout, abort} !== {1'b1, exp_flags}) begin n_fail++; $display("FAIL rnd%0d_result got=%b exp=%b", r, {done, match, timeout, abort}, {1'b1, exp_flags}); end
            n_tests++; if (seq_addr !== LEN_W'(end_idx)) begin n_fail++; $display("FAIL rnd%0d_addr got=%0d exp=%0d", r, seq_addr, end_idx); end
            tick();
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_busy got=%b exp=0", r, busy); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 2'd0;
        test_reset();
        test_sequence();
        test_mismatch();
        test_timeout();
        test_abort_and_drop();
        test_zero_len_and_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
